dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Sits between the CPU data port and the 2-way, 16-set data-cache SRAM (`dcache_sram`).
- Also sits between that SRAM and the off-chip data memory.
- Decodes CPU addresses, detects hits, and merges 32-bit CPU writes into 256-bit lines.
- Sequences dirty-line write-back and line refill through a memory request/ack handshake. The CPU is stalled for the whole miss.

Parameters:
- ADDR_W, 32, CPU byte address width.
- WORD_W, 32, CPU data word width.
- LINE_W, 256, cache line width (8 words, 32 bytes).
- IDX_W, 4, set index width (16 sets).
- TAG_W, 23, stored address-tag width. SRAM tag field is TAG_W+2: {valid, dirty, tag}.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- cpu_req_i  in  1  CPU access request.
- cpu_write_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data.
- cpu_stall_o  out  1  CPU must hold its request.
- mem_enable_o  out  1  memory request.
- mem_write_o  out  1  1 = line write-back.
- mem_addr_o  out  32  line-aligned memory address.
- mem_data_o  out  256  write-back line.
- mem_data_i  in  256  refill line.
- mem_ack_i  in  1  one-cycle completion pulse.
- sram_addr_o  out  4  set index.
- sram_tag_o  out  25  {valid, dirty, tag} to SRAM.
- sram_data_o  out  256  line to SRAM.
- sram_enable_o  out  1  SRAM access (SRAM updates LRU on it).
- sram_write_o  out  1  SRAM write.
- sram_tag_i  in  25  tag of hit way, or LRU victim way on miss.
- sram_data_i  in  256  line of hit way, or victim line.
- sram_hit_i  in  1  hit.

Behaviour:
- Address split:
  - tag = cpu_addr_i[31:9]
  - index = cpu_addr_i[8:5]
  - word = cpu_addr_i[4:2]
  - bits [1:0] ignored.
  - sram_addr_o = index in all states.
- States: IDLE, MISS, WRITEBACK, READMISS, READMISSOK. Reset state is IDLE.
- IDLE:
  - With cpu_req_i & sram_hit_i: sram_enable_o = 1, combinational.
  - Load hit: cpu_data_o = sram_data_i[32*word +: 32]; sram_write_o = 0.
  - Store hit: sram_write_o = 1; sram_data_o = sram_data_i with the selected word replaced by cpu_data_i; sram_tag_o = {1, 1, tag}.
  - With cpu_req_i & ~sram_hit_i: sram_enable_o = 0 so LRU is untouched; next state is MISS.
- MISS:
  - If sram_tag_i[24] & sram_tag_i[23] (victim valid and dirty): go to WRITEBACK.
  - Otherwise: go to READMISS.
- WRITEBACK:
  - mem_enable_o = 1, mem_write_o = 1.
  - mem_addr_o = {sram_tag_i[22:0], index, 5'b0}; mem_data_o = sram_data_i.
  - Outputs held stable until mem_ack_i; on mem_ack_i go to READMISS.
- READMISS:
  - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0}.
  - On mem_ack_i: register mem_data_i into a line buffer and go to READMISSOK.
- READMISSOK:
  - sram_enable_o = 1, sram_write_o = 1, sram_tag_o = {1, 0, tag}, sram_data_o = line buffer.
  - SRAM sees a miss, so it fills the LRU way and flips LRU.
  - Next state is IDLE. The retried access then hits; a store merges in that cycle.
- Stall: cpu_stall_o = (state != IDLE) | (cpu_req_i & ~sram_hit_i). It deasserts in the IDLE cycle in which the retried access hits.
  - Miss latency, clean victim: 3 cycles + memory latency.
  - Miss latency, dirty victim: add the write-back memory latency.
- Reset values:
  - mem_enable_o, mem_write_o, sram_enable_o, sram_write_o, cpu_stall_o = 0.
  - mem_addr_o, mem_data_o, cpu_data_o = 0 while idle with no request.
- Outputs are registered or held from state; mem_* must not glitch during WRITEBACK or READMISS.
- CPU inputs are stable while stalled. The controller samples the address combinationally and does not latch it.
- mem_ack_i outside WRITEBACK/READMISS is ignored.
- Reset asserted mid-miss: immediately IDLE, mem_enable_o = 0. The partial refill is discarded and the SRAM is not written.
- cpu_req_i = 0 in IDLE: all enables 0 and no LRU update.

Decomposition:
- Shared package `dcache_pkg`:
  - state enum.
  - widths: ADDR_W, LINE_W, TAG_W, IDX_W, OFFSET_W = 5.
  - tag-field bit positions: VALID_BIT = 24, DIRTY_BIT = 23.
- Sub-module `dcache_word_merge`: combinational word select for loads and word replace for stores, keyed by the 3-bit word index.

Test Plan:
- Cold load miss: addr 0x0000_0124, memory line word 1 = 0xDEADBEEF.
  - Stall for the miss; mem_addr_o = 0x0000_0120, mem_write_o = 0.
  - SRAM written with tag {1, 0, 0}.
  - Then cpu_data_o = 0xDEADBEEF with stall low.
- Store hit: store 0x12345678 to 0x0000_0128 after the refill.
  - No stall; sram_write_o = 1, tag dirty bit = 1.
  - Only bits [95:64] of the line change.
- Dirty eviction: fill both ways of set 9 (0x0000_0120, 0x0000_1120), dirty one, then miss 0x0000_2120.
  - WRITEBACK issues mem_addr_o of the dirty LRU line with its data.
  - Then READMISS to 0x0000_2120.
- Clean eviction: same as the dirty-eviction case with both lines clean. No WRITEBACK state; the first memory request is the read.
- Slow memory: mem_ack_i delayed 10 cycles. mem_* outputs and stall are held constant throughout; a spurious ack in IDLE has no effect.
- Reset asserted in READMISS: mem_enable_o drops asynchronously, state is IDLE, and no SRAM write occurs.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths, tag-field layout and controller state type
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 256;
    localparam int IDX_W      = 4;
    localparam int TAG_W      = 23;
    localparam int OFFSET_W   = 5;
    localparam int WSEL_W     = 3;
    localparam int SRAM_TAG_W = TAG_W + 2;

    // SRAM tag field is {valid, dirty, tag}
    localparam int VALID_BIT = 24;
    localparam int DIRTY_BIT = 23;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_READMISS,
        S_READMISSOK
    } state_e;

endpackage

// File: rtl/dcache_word_merge.sv
// rtl/dcache_word_merge.sv - word select for loads and word replace for stores
module dcache_word_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [WSEL_W-1:0] word_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic [LINE_W-1:0] line_o
);

    logic [7:0] bit_base;

    assign bit_base = {word_i, 5'b00000};

    // load path: pick the addressed 32-bit word out of the line
    always_comb begin
        rdata_o = line_i[bit_base +: WORD_W];
    end

    // store path: same line with only the addressed word replaced
    always_comb begin
        line_o                       = line_i;
        line_o[bit_base +: WORD_W]   = wdata_i;
    end

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - 2-way data cache controller: hit detect, store merge, write-back and refill
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_write_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [WORD_W-1:0]     cpu_data_i,
    output logic [WORD_W-1:0]     cpu_data_o,
    output logic                  cpu_stall_o,
    output logic                  mem_enable_o,
    output logic                  mem_write_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [LINE_W-1:0]     mem_data_o,
    input  logic [LINE_W-1:0]     mem_data_i,
    input  logic                  mem_ack_i,
    output logic [IDX_W-1:0]      sram_addr_o,
    output logic [SRAM_TAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0]     sram_data_o,
    output logic                  sram_enable_o,
    output logic                  sram_write_o,
    input  logic [SRAM_TAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0]     sram_data_i,
    input  logic                  sram_hit_i
);

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   line_buf_q, line_buf_d;

    logic [TAG_W-1:0]    addr_tag;
    logic [IDX_W-1:0]    addr_idx;
    logic [WSEL_W-1:0]   addr_word;
    logic                unused_byte_bits;
    logic [WORD_W-1:0]   hit_word;
    logic [LINE_W-1:0]   merged_line;

    // the address is used straight from the CPU; it is held stable while stalled
    assign addr_tag         = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign addr_idx         = cpu_addr_i[OFFSET_W +: IDX_W];
    assign addr_word        = cpu_addr_i[2 +: WSEL_W];
    assign unused_byte_bits = ^cpu_addr_i[1:0];
    assign sram_addr_o      = addr_idx;

    dcache_word_merge u_merge (
        .line_i  (sram_data_i),
        .word_i  (addr_word),
        .wdata_i (cpu_data_i),
        .rdata_o (hit_word),
        .line_o  (merged_line)
    );

    // stall covers the detecting IDLE cycle and every cycle until the retry hits
    assign cpu_stall_o = (state_q != S_IDLE) | (cpu_req_i & ~sram_hit_i);

    // next-state and output decode; all outputs derive from state and stable inputs
    always_comb begin
        state_d       = state_q;
        line_buf_d    = line_buf_q;
        cpu_data_o    = '0;
        mem_enable_o  = 1'b0;
        mem_write_o   = 1'b0;
        mem_addr_o    = '0;
        mem_data_o    = '0;
        sram_tag_o    = '0;
        sram_data_o   = '0;
        sram_enable_o = 1'b0;
        sram_write_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i) begin
                    if (sram_hit_i) begin
                        sram_enable_o = 1'b1;
                        if (cpu_write_i) begin
                            sram_write_o = 1'b1;
                            sram_data_o  = merged_line;
                            sram_tag_o   = {1'b1, 1'b1, addr_tag};
                        end else begin
                            cpu_data_o = hit_word;
                        end
                    end else begin
                        // no SRAM enable on a miss so the LRU bit is left alone
                        state_d = S_MISS;
                    end
                end
            end
            S_MISS: begin
                if (sram_tag_i[VALID_BIT] && sram_tag_i[DIRTY_BIT]) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_READMISS;
                end
            end
            S_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {sram_tag_i[TAG_W-1:0], addr_idx, {OFFSET_W{1'b0}}};
                mem_data_o   = sram_data_i;
                if (mem_ack_i) begin
                    state_d = S_READMISS;
                end
            end
            S_READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {addr_tag, addr_idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    line_buf_d = mem_data_i;
                    state_d    = S_READMISSOK;
                end
            end
            S_READMISSOK: begin
                // SRAM sees a miss here, so it fills its LRU way
                sram_enable_o = 1'b1;
                sram_write_o  = 1'b1;
                sram_tag_o    = {1'b1, 1'b0, addr_tag};
                sram_data_o   = line_buf_q;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // state and refill line buffer; reset abandons any miss in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            line_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            line_buf_q <= line_buf_d;
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - randomized self-checking bench with SRAM, memory and cache reference models
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_ack_i;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_enable_o, sram_write_o, sram_hit_i;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- architectural memory view ----------------
    logic [31:0]  ref_words [logic [31:0]];
    logic [255:0] mem_lines [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return {wa[15:0], ~wa[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] wa);
        if (ref_words.exists(wa)) return ref_words[wa];
        return init_word(wa);
    endfunction

    function automatic logic [255:0] ref_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_word(la + 32'(i*4));
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] la);
        logic [255:0] l;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i*4));
        return l;
    endfunction

    // ---------------- 2-way SRAM model ----------------
    logic         sram_clear = 1'b1;
    logic [24:0]  s_tag  [16][2];
    logic [255:0] s_data [16][2];
    logic         s_lru  [16];
    int           fill_cnt;
    logic [24:0]  last_fill_tag;
    logic [3:0]   b_idx;
    logic         b_h0, b_h1, b_way;

    always_comb begin
        b_idx       = sram_addr_o;
        b_h0        = s_tag[b_idx][0][24] && (s_tag[b_idx][0][22:0] == cpu_addr_i[31:9]);
        b_h1        = s_tag[b_idx][1][24] && (s_tag[b_idx][1][22:0] == cpu_addr_i[31:9]);
        sram_hit_i  = b_h0 | b_h1;
        b_way       = b_h0 ? 1'b0 : (b_h1 ? 1'b1 : s_lru[b_idx]);
        sram_tag_i  = s_tag[b_idx][b_way];
        sram_data_i = s_data[b_idx][b_way];
    end

    always @(posedge clk_i) begin
        if (sram_clear) begin
            for (int s = 0; s < 16; s++) begin
                s_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    s_tag[s][w]  <= '0;
                    s_data[s][w] <= '0;
                end
            end
            fill_cnt      <= 0;
            last_fill_tag <= '0;
        end else if (sram_enable_o) begin
            s_lru[b_idx] <= ~b_way;
            if (sram_write_o) begin
                s_tag[b_idx][b_way]  <= sram_tag_o;
                s_data[b_idx][b_way] <= sram_data_o;
                if (!sram_hit_i) begin
                    fill_cnt      <= fill_cnt + 1;
                    last_fill_tag <= sram_tag_o;
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    int           mem_lat = 1;
    bit           spurious = 0;
    bit           ev_wr [$];
    logic [31:0]  ev_addr [$];

    initial begin
        int           cnt;
        int           unstable;
        logic [31:0]  r_addr;
        logic         r_wr;
        logic [255:0] r_data;
        cnt = 0; unstable = 0; r_addr = '0; r_wr = 1'b0; r_data = '0;
        mem_ack_i = 1'b0;
        mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            mem_ack_i = 1'b0;
            if (!rst_i) begin
                cnt = 0;
            end else if (mem_enable_o) begin
                if (cnt == 0) begin
                    r_addr = mem_addr_o; r_wr = mem_write_o; r_data = mem_data_o; unstable = 0;
                end else if (mem_addr_o !== r_addr || mem_write_o !== r_wr ||
                             (r_wr && mem_data_o !== r_data) || cpu_stall_o !== 1'b1) begin
                    unstable++;
                end
                cnt++;
                if (cnt >= mem_lat) begin
                    check("mem_stable", 32'(unstable), 0);
                    if (r_wr) begin
                        check("wb_data", r_data, ref_line(r_addr));
                        mem_lines[r_addr] = r_data;
                    end else begin
                        mem_data_i = mem_line(r_addr);
                    end
                    ev_wr.push_back(r_wr);
                    ev_addr.push_back(r_addr);
                    mem_ack_i = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                if (spurious) begin
                    mem_ack_i = 1'b1;
                    mem_data_i = {8{32'hBAD0_BAD0}};
                    spurious = 0;
                end
            end
        end
    end

    // ---------------- cache-contents reference (MRU/LRU per set) ----------------
    logic [31:0] mru_line [16];
    logic [31:0] lru_line [16];
    bit          mru_v [16];
    bit          lru_v [16];
    bit          dirty_map [logic [31:0]];

    task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0]  la, wa;
        logic [3:0]   idx;
        logic [255:0] exp_line;
        bit           exp_hit, exp_wb;
        int           exp_stall, fills0, stalls;
        la  = {addr[31:5], 5'b0};
        wa  = {addr[31:2], 2'b0};
        idx = addr[8:5];
        exp_hit = (mru_v[idx] && mru_line[idx] == la) || (lru_v[idx] && lru_line[idx] == la);
        exp_wb  = !exp_hit && lru_v[idx] && dirty_map.exists(lru_line[idx]);
        exp_stall = exp_hit ? 0 : (3 + mem_lat + (exp_wb ? mem_lat : 0));
        ev_wr.delete();
        ev_addr.delete();
        fills0 = fill_cnt;

        @(negedge clk_i);
        cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = addr; cpu_data_i = wd;
        stalls = 0;
        #1;
        while (cpu_stall_o && stalls < 200) begin
            stalls++;
            @(negedge clk_i);
            #1;
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        check("n_mem_req", 32'(ev_wr.size()), exp_hit ? 0 : (exp_wb ? 2 : 1));
        if (ev_wr.size() == (exp_wb ? 2 : 1) && !exp_hit) begin
            if (exp_wb) begin
                check("wb_req", {ev_wr[0], ev_addr[0]}, {1'b1, lru_line[idx]});
            end
            check("rd_req", {ev_wr[ev_wr.size()-1], ev_addr[ev_addr.size()-1]}, {1'b0, la});
        end
        if (!exp_hit) begin
            check("fill_cnt", 32'(fill_cnt - fills0), 1);
            check("fill_tag", last_fill_tag, {2'b10, addr[31:9]});
        end
        check("hit_enable", sram_enable_o, 1'b1);
        if (wr) begin
            exp_line = ref_line(la);
            exp_line[addr[4:2]*32 +: 32] = wd;
            check("st_we", sram_write_o, 1'b1);
            check("st_tag", sram_tag_o, {2'b11, addr[31:9]});
            check("st_line", sram_data_o, exp_line);
        end else begin
            check("ld_we", sram_write_o, 1'b0);
            check("ld_data", cpu_data_o, ref_word(wa));
        end
        @(posedge clk_i);
        #1;
        cpu_req_i = 1'b0;

        if (exp_hit) begin
            if (lru_v[idx] && lru_line[idx] == la) begin
                lru_line[idx] = mru_line[idx];
                lru_v[idx]    = mru_v[idx];
                mru_line[idx] = la;
                mru_v[idx]    = 1'b1;
            end
        end else begin
            if (lru_v[idx]) dirty_map.delete(lru_line[idx]);
            lru_line[idx] = mru_line[idx];
            lru_v[idx]    = mru_v[idx];
            mru_line[idx] = la;
            mru_v[idx]    = 1'b1;
        end
        if (wr) begin
            ref_words[wa]  = wd;
            dirty_map[la]  = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        for (int s = 0; s < 16; s++) begin
            mru_v[s] = 0; lru_v[s] = 0; mru_line[s] = '0; lru_line[s] = '0;
        end
        cpu_req_i = 0; cpu_write_i = 0; cpu_addr_i = '0; cpu_data_i = '0;
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        sram_clear = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("rst_ctrl", {mem_enable_o, mem_write_o, sram_enable_o, sram_write_o, cpu_stall_o}, 0);
        check("rst_data", {mem_addr_o, mem_data_o, cpu_data_o}, 0);

        // cold load miss with a known word in memory
        ref_words[32'h0000_0124] = 32'hDEAD_BEEF;
        mem_lines[32'h0000_0120] = ref_line(32'h0000_0120);
        mem_lat = 2;
        do_access(0, 32'h0000_0124, 0);
        check("cold_value", ref_word(32'h0000_0124), 32'hDEAD_BEEF);

        // store hit, then fill the second way, then dirty and clean evictions
        do_access(1, 32'h0000_0128, 32'h1234_5678);
        mem_lat = 1;
        do_access(0, 32'h0000_1120, 0);
        mem_lat = 3;
        do_access(0, 32'h0000_2120, 0);
        do_access(0, 32'h0000_3120, 0);

        // slow memory on a dirty eviction
        do_access(1, 32'h0000_2128, 32'hCAFE_0001);
        do_access(1, 32'h0000_3124, 32'hCAFE_0002);
        mem_lat = 10;
        do_access(0, 32'h0000_4120, 0);

        // spurious ack while idle
        spurious = 1;
        repeat (3) @(negedge clk_i);
        #1;
        check("spur_idle", {cpu_stall_o, mem_enable_o, sram_enable_o}, 0);
        mem_lat = 2;
        do_access(0, 32'h0000_4124, 0);

        // reset asserted in the middle of a refill
        mem_lat = 10;
        w = fill_cnt;
        @(negedge clk_i);
        cpu_req_i = 1; cpu_write_i = 0; cpu_addr_i = 32'h0000_5140;
        for (int k = 0; k < 20 && !(mem_enable_o && !mem_write_o); k++) begin
            @(negedge clk_i);
            #1;
        end
        check("rm_reached", {mem_enable_o, mem_write_o}, 2'b10);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        cpu_req_i = 1'b0;
        #1;
        check("rst_async", {mem_enable_o, sram_enable_o, cpu_stall_o}, 0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_no_fill", 32'(fill_cnt - w), 0);
        check("rst_idle", {mem_enable_o, cpu_stall_o}, 0);
        mem_lat = 2;
        do_access(0, 32'h0000_5140, 0);

        // randomized traffic over a few conflicting sets
        for (int n = 0; n < 200; n++) begin
            int t, ix, wd;
            t  = $urandom_range(0, 3);
            ix = $urandom_range(8, 11);
            wd = $urandom_range(0, 7);
            mem_lat = $urandom_range(1, 4);
            do_access(1'($urandom_range(0, 1)), 32'(t * 512 + ix * 32 + wd * 4), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
